// File: rtl/comb_sched_pkg.sv
// Shared constants for the combination-engine job scheduler: FSM state
// encoding, default widths and the watchdog counter width helper.
package comb_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_N_W         = 4;
  localparam int DEF_RES_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Watchdog counts 0 .. cyc-1, so clog2(cyc) bits suffice (minimum 1).
  function automatic int timeout_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/comb_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first set request at or
// after ptr, wrapping modulo NUM_REQ, as a one-hot vector plus its index.
module comb_rr_arbiter
  import comb_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any && req[IDX_W'((int'(ptr) + off) % NUM_REQ)]) begin
        any = 1'b1;
        gnt[IDX_W'((int'(ptr) + off) % NUM_REQ)] = 1'b1;
        idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/comb_job_scheduler.sv
// Round-robin scheduler sharing one C(n,m) engine between NUM_REQ clients.
// Optional watchdog on the engine is enabled with `define COMB_TIMEOUT_EN.
module comb_job_scheduler
  import comb_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int N_W         = DEF_N_W,
  parameter int RES_W       = DEF_RES_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  input  logic [NUM_REQ*N_W-1:0] req_m,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [RES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   eng_start,
  output logic [N_W-1:0]         eng_n,
  output logic [N_W-1:0]         eng_m,
  output logic                   eng_rst,
  input  logic                   eng_done,
  input  logic [RES_W-1:0]       eng_result,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   id;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [N_W-1:0]     sel_n;
  logic [N_W-1:0]     sel_m;
  logic               timeout;

  comb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_n = '0;
    sel_m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_n = req_n[i*N_W +: N_W];
        sel_m = req_m[i*N_W +: N_W];
      end
    end
  end

`ifdef COMB_TIMEOUT_EN
  localparam int TW = timeout_w(TIMEOUT_CYC);

  logic [TW-1:0] wait_cnt;

  // Fires during the TIMEOUT_CYC-th WAIT cycle if the engine is still silent.
  assign timeout = (state == ST_WAIT) && !eng_done &&
                   (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign eng_rst = rst | timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign eng_rst = rst;
`endif

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id        <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_n     <= '0;
      eng_m     <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            id      <= arb_idx;
            gnt     <= arb_gnt;
            rsp_err <= 1'b0;
            if (sel_m > sel_n) begin
              // C(n,m) is zero when m > n; the engine is never bothered.
              rsp_data <= '0;
              state    <= ST_RESP;
            end else begin
              eng_n     <= sel_n;
              eng_m     <= sel_m;
              eng_start <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (eng_done) begin
            rsp_data <= eng_result;
            state    <= ST_RESP;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= NUM_REQ'(1) << id;
          ptr       <= (id == IDX_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_job_scheduler.sv
// Self-checking bench for comb_job_scheduler: behavioural engine, directed and
// random jobs, round-robin order, mid-job reset and the watchdog path.
module tb_comb_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int N_W     = 4;
  localparam int RES_W   = 16;
  localparam int TO_CYC  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*N_W-1:0] req_n;
  logic [NUM_REQ*N_W-1:0] req_m;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [RES_W-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   eng_start;
  logic [N_W-1:0]         eng_n;
  logic [N_W-1:0]         eng_m;
  logic                   eng_rst;
  logic                   eng_done;
  logic [RES_W-1:0]       eng_result;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  comb_job_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .N_W         (N_W),
    .RES_W       (RES_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_n      (req_n),
    .req_m      (req_m),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_n      (eng_n),
    .eng_m      (eng_m),
    .eng_rst    (eng_rst),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Binomial coefficient from its definition, zero when m > n.
  function automatic int comb(input int n, input int m);
    longint r;
    if (m > n) return 0;
    r = 1;
    for (int i = 1; i <= m; i++) r = r * (n - m + i) / i;
    return int'(r) & 32'hFFFF;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // Behavioural engine: answers eng_delay cycles after start unless hung.
  int             eng_cnt   = 0;
  int             eng_delay = 1;
  logic           eng_hang  = 1'b0;
  logic [N_W-1:0] cap_n, cap_m;

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
  end

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_rst) begin
      eng_cnt = 0;
    end else if (eng_start) begin
      cap_n   = eng_n;
      cap_m   = eng_m;
      eng_cnt = eng_hang ? -1 : eng_delay;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        eng_result = RES_W'(comb(int'(cap_n), int'(cap_m)));
      end
    end
  end

  // Activity monitor: start and watchdog-reset counts, grants during a job.
  int   start_cnt = 0;
  int   erst_cnt  = 0;
  int   gnt_viol  = 0;
  logic in_job    = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_job = 1'b0;
    end else begin
      if (eng_start) start_cnt++;
      if (eng_rst) erst_cnt++;
      if (gnt != 0) begin
        if (in_job) gnt_viol++;
        in_job = 1'b1;
      end
      if (rsp_valid != 0) in_job = 1'b0;
    end
  end

  int ptr_m = 0;

  // One job from a single requester, checked end to end including latency.
  task automatic do_job(input int r, input int n, input int m, input int d);
    int   lat, s0;
    logic bypass;
    bypass    = (m > n);
    eng_delay = d;
    s0        = start_cnt;
    req_n[r*N_W +: N_W] = N_W'(n);
    req_m[r*N_W +: N_W] = N_W'(m);
    req[r] = 1'b1;
    lat = 0;
    while (gnt == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("gnt_onehot", gnt, 64'(1) << r);
    check("gnt_lat", lat, 1);
    req[r] = 1'b0;
    if (!bypass) begin
      check("eng_start", eng_start, 1);
      check("eng_nm", {eng_n, eng_m}, {N_W'(n), N_W'(m)});
    end
    while (rsp_valid == 0 && lat < 100 + d) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid", rsp_valid, 64'(1) << r);
    check("rsp_data", rsp_data, comb(n, m));
    check("rsp_err", rsp_err, 0);
    check("rsp_lat", lat, bypass ? 2 : 3 + d);
    check("start_cnt", start_cnt - s0, bypass ? 0 : 1);
    ptr_m = (r + 1) % NUM_REQ;
  endtask

  initial begin
    int   lat, g, exp_g, n_i, m_i;
    logic flag;
    logic [N_W-1:0] ops_n [NUM_REQ];
    logic [N_W-1:0] ops_m [NUM_REQ];

    rst   = 1'b1;
    req   = '0;
    req_n = '0;
    req_m = '0;
    @(negedge clk);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_outs", {gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_n, eng_m, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_n, eng_m, busy, eng_rst}, 0);

    // Single job, bypass, and edge operands.
    do_job(0, 5, 2, 20);
    do_job(2, 3, 5, 4);
    do_job(1, 4, 4, 3);
    do_job(3, 4, 0, 1);
    do_job(0, 15, 7, 7);

    // Random jobs from random requesters.
    for (int k = 0; k < 10; k++)
      do_job($urandom_range(NUM_REQ - 1, 0), $urandom_range(15, 0),
             $urandom_range(15, 0), $urandom_range(8, 1));

    // Reset while the engine is mid-run: job abandoned, pointer back to 0.
    eng_delay = 30;
    req_n[3*N_W +: N_W] = 4'd6;
    req_m[3*N_W +: N_W] = 4'd3;
    req[3] = 1'b1;
    lat = 0;
    while (gnt == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("abort_gnt", gnt, 4'b1000);
    req[3] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_eng_rst", eng_rst, 1);
    check("abort_outs", {gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_n, eng_m, busy}, 0);
    rst   = 1'b0;
    ptr_m = 0;
    flag  = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) flag = 1'b1;
    end
    check("abort_no_rsp", flag, 0);

    // Round-robin with all requesters held: order follows the pointer.
    gnt_viol = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ops_n[i] = N_W'($urandom_range(15, 0));
      ops_m[i] = N_W'($urandom_range(int'(ops_n[i]), 0));
      req_n[i*N_W +: N_W] = ops_n[i];
      req_m[i*N_W +: N_W] = ops_m[i];
    end
    req = '1;
    for (int k = 0; k < 5; k++) begin
      eng_delay = $urandom_range(5, 1);
      exp_g = rr_pick(req, ptr_m);
      lat = 0;
      while (gnt == 0 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("rr_gnt", gnt, 64'(1) << exp_g);
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) g = i;
      req[g] = 1'b0;
      n_i = int'(ops_n[g]);
      m_i = int'(ops_m[g]);
      lat = 0;
      while (rsp_valid == 0 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("rr_rsp_valid", rsp_valid, 64'(1) << g);
      check("rr_rsp_data", rsp_data, comb(n_i, m_i));
      ptr_m = (g + 1) % NUM_REQ;
      if (k < 4) req[g] = 1'b1;
      else req = '0;
    end
    check("rr_grant_expected_order_last", g, 0);
    check("gnt_while_busy", gnt_viol, 0);

    // Engine that never answers.
    eng_hang = 1'b1;
    erst_cnt = 0;
    req_n[1*N_W +: N_W] = 4'd9;
    req_m[1*N_W +: N_W] = 4'd4;
    req[1] = 1'b1;
`ifdef COMB_TIMEOUT_EN
    lat = 0;
    while (!eng_rst && lat < 60) begin
      @(negedge clk);
      lat++;
      if (gnt != 0) req[1] = 1'b0;
    end
    check("to_eng_rst_lat", lat, 2 + TO_CYC - 1);
    while (rsp_valid == 0 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check("to_rsp_valid", rsp_valid, 4'b0010);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 0);
    check("to_rsp_lat", lat, TO_CYC + 3);
    check("to_eng_rst_cnt", erst_cnt, 1);
`else
    lat = 0;
    while (gnt == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("hang_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!busy || rsp_valid != 0 || eng_rst) flag = 1'b1;
    end
    check("hang_busy_held", flag, 0);
    rst = 1'b1;
    @(negedge clk);
    check("hang_rst_eng_rst", eng_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("hang_rst_idle", busy, 0);
`endif
    eng_hang = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comb_job_scheduler.md
Name: comb_job_scheduler

Overview:
Shares one stack-based combination engine, which computes C(n,m), between NUM_REQ requesters. Arbitrates pending requests round-robin, loads n/m into the engine, pulses its start, and waits for its done. Latches the result and returns it to the granted requester with a one-cycle response pulse. Sits between client blocks and the existing combination controller/datapath pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
N_W, 4, width of n and m operands
RES_W, 16, width of engine result
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous active-high
req  in  NUM_REQ  per-requester level request
req_n  in  NUM_REQ*N_W  packed n operands, slice i = requester i
req_m  in  NUM_REQ*N_W  packed m operands
gnt  out  NUM_REQ  one-hot, 1-cycle pulse when job accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when result ready
rsp_data  out  RES_W  result, valid while rsp_valid nonzero
rsp_err  out  1  error flag qualified by rsp_valid
eng_start  out  1  1-cycle start pulse to engine
eng_n, eng_m  out  N_W each  operands to engine, held stable from ISSUE to done
eng_rst  out  1  engine reset request
eng_done  in  1  engine completion pulse
eng_result  in  RES_W  engine result, valid with eng_done
busy  out  1  high in any state except IDLE

Behaviour:
- Reset is synchronous and active-high, on clk rising edge. It forces state IDLE, round-robin pointer 0, and all outputs to 0, including rsp_data and eng_n/eng_m. eng_rst is asserted for the reset cycle. Reset mid-job abandons the job and produces no rsp_valid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ. At the edge, latch id, n and m, and pulse gnt[id] next cycle.
  - If m > n: go to RESP with result 0; eng_start is never raised.
  - Otherwise: go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle, eng_n/eng_m driven from the latched values. Go to WAIT.
- WAIT: hold eng_n/eng_m. On eng_done, latch eng_result into rsp_data and go to RESP. eng_done outside WAIT is ignored.
- RESP: rsp_valid[id]=1 for one cycle with rsp_data and rsp_err. The pointer becomes (id+1) mod NUM_REQ. Go to IDLE.
- req is sampled only in IDLE. A requester must drop req by the cycle after gnt, or it is re-served as a new job.
- Minimum latency, req to rsp_valid:
  - m > n bypass: 2 cycles.
  - Engine path: 3 cycles plus the engine run time.
- Simultaneous req while not IDLE: held pending, no loss, no grant.
- Operand widths are unsigned. rsp_data is zero-extended or truncated to RES_W; RES_W is sized so C(2^N_W-1, *) fits.

Optional Feature:
COMB_TIMEOUT_EN:
- With the macro: a cycle counter runs in WAIT.
  - Reaching TIMEOUT_CYC without eng_done → pulse eng_rst for one cycle, rsp_data=0, rsp_err=1, go to RESP.
  - The counter clears on entry to ISSUE.
- Without the macro: no counter; WAIT waits indefinitely; rsp_err is constant 0; eng_rst is asserted only during rst.

Decomposition:
- Package comb_sched_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3), default widths, and a TIMEOUT_W function derived from TIMEOUT_CYC.
- One sub-module, comb_rr_arbiter: combinational rotate-priority pick from req and pointer, output one-hot grant plus index. The scheduler FSM instantiates it.

Test Plan:
1. Single job: req[0], n=5, m=2, engine model returns 10 after 20 cycles → gnt[0] one pulse, one eng_start, eng_n=5, eng_m=2, rsp_valid[0] with rsp_data=10, rsp_err=0.
2. Bypass: req[2], n=3, m=5 → rsp_valid[2] 2 cycles after the req edge, rsp_data=0, eng_start never high.
3. Round-robin fairness: req=4'b1111 held, each requester drops after its gnt and re-raises → grant order 0,1,2,3,0, and nothing is granted while busy=1.
4. Edge values: (n=4, m=4) → 1; (n=4, m=0) → 1; (n=15, m=7) → 6435. Each result arrives in order with the correct rsp_valid bit.
5. Reset mid-WAIT: assert rst for 1 cycle while in WAIT → next cycle state IDLE, all outputs 0, no rsp_valid for the aborted job, pointer 0; a subsequent job completes normally.
6. COMB_TIMEOUT_EN, TIMEOUT_CYC=16, engine never returns done → eng_rst pulse at the 16th WAIT cycle, then rsp_valid with rsp_err=1, rsp_data=0. Without the macro, busy stays high.
